// File: rtl/ssd_capture_if.sv
// Display-pin and update-stream bundle for ssd_capture; slave = capture block, master = board/bench side.
// SSD_CAPTURE_DP_EN adds the decimal-point pin and its captured/update outputs.
interface ssd_capture_if #(parameter int NDIG = 4);
    localparam int DW = $clog2(NDIG);

    logic [6:0]        seg_n;
    logic [NDIG-1:0]   an_n;
    logic [4*NDIG-1:0] hex_out;
    logic [NDIG-1:0]   digit_valid;
    logic              upd_valid;
    logic              upd_ready;
    logic [DW-1:0]     upd_digit;
    logic [3:0]        upd_value;
    logic              bad_pattern;
    logic              overrun;
    logic              clr_err;
`ifdef SSD_CAPTURE_DP_EN
    logic              dp_n;
    logic [NDIG-1:0]   dp_out;
    logic              upd_dp;
`endif

    modport slave (
`ifdef SSD_CAPTURE_DP_EN
        input  dp_n,
        output dp_out, upd_dp,
`endif
        input  seg_n, an_n, upd_ready, clr_err,
        output hex_out, digit_valid, upd_valid, upd_digit, upd_value, bad_pattern, overrun
    );

    modport master (
`ifdef SSD_CAPTURE_DP_EN
        output dp_n,
        input  dp_out, upd_dp,
`endif
        output seg_n, an_n, upd_ready, clr_err,
        input  hex_out, digit_valid, upd_valid, upd_digit, upd_value, bad_pattern, overrun
    );
endinterface

// File: rtl/ssd_capture.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus and reports changes as an update stream.
// Optional feature macro: SSD_CAPTURE_DP_EN (decimal point captured and compared alongside the segments).
module ssd_capture #(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 8
) (
    input logic         clk,
    input logic         rst_n,
    ssd_capture_if.slave bus
);
    localparam int DW = $clog2(NDIG);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
`ifdef SSD_CAPTURE_DP_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
`endif

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, WAIT_REL} state_t;

    logic [SW-1:0]         pins, s_m, s_s, s_p, cap_s;
    logic [NDIG-1:0]       a_m, a_s, a_p, cap_a;
    logic [CW-1:0]         cnt;
    state_t                state, state_nx;
    logic [NDIG-1:0][3:0]  hex_q;
    logic [NDIG-1:0]       dv_q;
    logic                  upd_vld, bad_q, ovr_q;
    logic [DW-1:0]         upd_dig, dig;
    logic [3:0]            upd_val, dec_val;
    logic                  dec_ok, p_onehot, stable, cap_chg, ev;

`ifdef SSD_CAPTURE_DP_EN
    logic [NDIG-1:0]       dp_q;
    logic                  upd_dp_q;
    assign pins = {bus.dp_n, bus.seg_n};
`else
    assign pins = bus.seg_n;
`endif

    function automatic logic one_low(input logic [NDIG-1:0] an);
        logic [NDIG-1:0] x;
        x = ~an;
        return (x != '0) && ((x & (x - 1'b1)) == '0);
    endfunction

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40: decode = {1'b1, 4'h0};  7'h79: decode = {1'b1, 4'h1};
            7'h24: decode = {1'b1, 4'h2};  7'h30: decode = {1'b1, 4'h3};
            7'h19: decode = {1'b1, 4'h4};  7'h12: decode = {1'b1, 4'h5};
            7'h02: decode = {1'b1, 4'h6};  7'h78: decode = {1'b1, 4'h7};
            7'h00: decode = {1'b1, 4'h8};  7'h10: decode = {1'b1, 4'h9};
            7'h08: decode = {1'b1, 4'hA};  7'h03: decode = {1'b1, 4'hB};
            7'h46: decode = {1'b1, 4'hC};  7'h21: decode = {1'b1, 4'hD};
            7'h06: decode = {1'b1, 4'hE};  7'h0E: decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

    // s_p/a_p is the sample whose run length cnt describes; all FSM decisions use it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_m <= '1; s_s <= '1; s_p <= '1;
            a_m <= '1; a_s <= '1; a_p <= '1;
            cnt <= '0;
        end else begin
            s_m <= pins;  s_s <= s_m;  s_p <= s_s;
            a_m <= bus.an_n; a_s <= a_m; a_p <= a_s;
            if ({s_s, a_s} != {s_p, a_p})
                cnt <= CW'(1);
            else if (cnt != CW'(STABLE_CYCLES))
                cnt <= cnt + 1'b1;
        end
    end

    assign p_onehot = one_low(a_p);
    assign stable   = (cnt == CW'(STABLE_CYCLES));
    assign cap_chg  = ({s_p, a_p} != {cap_s, cap_a});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (p_onehot) state_nx = SETTLE;
            SETTLE:   if (!p_onehot) state_nx = IDLE;
                      else if (stable) state_nx = CAPTURE;
            CAPTURE:  state_nx = WAIT_REL;
            WAIT_REL: if (cap_chg) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_s <= '1;
            cap_a <= '1;
        end else if (state == SETTLE && state_nx == CAPTURE) begin
            cap_s <= s_p;
            cap_a <= a_p;
        end
    end

    always_comb begin
        dig = '0;
        for (int i = 0; i < NDIG; i++)
            if (!cap_a[i]) dig = DW'(i);
    end

    assign {dec_ok, dec_val} = decode(cap_s[6:0]);
`ifdef SSD_CAPTURE_DP_EN
    assign ev = !dv_q[dig] || (hex_q[dig] != dec_val) || (dp_q[dig] != ~cap_s[7]);
`else
    assign ev = !dv_q[dig] || (hex_q[dig] != dec_val);
`endif

    // error sets are written after the clear so a same-cycle set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q   <= '0;
            dv_q    <= '0;
            upd_vld <= 1'b0;
            upd_dig <= '0;
            upd_val <= '0;
            bad_q   <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SSD_CAPTURE_DP_EN
            dp_q     <= '0;
            upd_dp_q <= 1'b0;
`endif
        end else begin
            if (upd_vld && bus.upd_ready) upd_vld <= 1'b0;
            if (bus.clr_err) begin
                bad_q <= 1'b0;
                ovr_q <= 1'b0;
            end
            if (state == CAPTURE) begin
                if (dec_ok) begin
                    hex_q[dig] <= dec_val;
                    dv_q[dig]  <= 1'b1;
`ifdef SSD_CAPTURE_DP_EN
                    dp_q[dig]  <= ~cap_s[7];
`endif
                    if (ev) begin
                        if (upd_vld && !bus.upd_ready) begin
                            ovr_q <= 1'b1;
                        end else begin
                            upd_vld <= 1'b1;
                            upd_dig <= dig;
                            upd_val <= dec_val;
`ifdef SSD_CAPTURE_DP_EN
                            upd_dp_q <= ~cap_s[7];
`endif
                        end
                    end
                end else begin
                    dv_q[dig] <= 1'b0;
                    bad_q     <= 1'b1;
                end
            end
        end
    end

    assign bus.hex_out     = hex_q;
    assign bus.digit_valid = dv_q;
    assign bus.upd_valid   = upd_vld;
    assign bus.upd_digit   = upd_dig;
    assign bus.upd_value   = upd_val;
    assign bus.bad_pattern = bad_q;
    assign bus.overrun     = ovr_q;
`ifdef SSD_CAPTURE_DP_EN
    assign bus.dp_out      = dp_q;
    assign bus.upd_dp      = upd_dp_q;
`endif
endmodule

// File: tb/tb_ssd_capture.sv
// Bench for ssd_capture: directed scenarios plus random hold-segments checked against a per-segment digit model.
module tb_ssd_capture;
    localparam int NDIG   = 4;
    localparam int STABLE = 8;
    localparam int LONG   = 18;   // segments this long always capture; segments <=5 never do

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ssd_capture_if #(.NDIG(NDIG)) bus();
    ssd_capture #(.NDIG(NDIG), .STABLE_CYCLES(STABLE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {int dig; int val;} ev_t;

    int   checks = 0, errors = 0;
    int   n_ev = 0, rmode = 0, lowrun = 0, lat, ev0;
    ev_t  exp_q[$];
    ev_t  mon_e;
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] m_hex [NDIG];
    logic       m_dv  [NDIG];
    logic       m_bad, m_ovr;
    logic [6:0] last_s;
    logic [3:0] last_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (seg_tab[i] == s) return i;
        return -1;
    endfunction

    function automatic int lit_digit(input logic [3:0] a);
        int n = 0, d = -1;
        for (int i = 0; i < NDIG; i++) if (!a[i]) begin n++; d = i; end
        return (n == 1) ? d : -1;
    endfunction

    function automatic logic [15:0] m_hex_word();
        logic [15:0] w = '0;
        for (int i = 0; i < NDIG; i++) w[4*i +: 4] = m_hex[i];
        return w;
    endfunction

    function automatic logic [3:0] m_dv_word();
        logic [3:0] w = '0;
        for (int i = 0; i < NDIG; i++) w[i] = m_dv[i];
        return w;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NDIG; i++) begin m_hex[i] = 4'h0; m_dv[i] = 1'b0; end
        m_bad = 1'b0; m_ovr = 1'b0;
        exp_q.delete();
    endtask

    // predicted outcome of holding one pin pair for len cycles
    task automatic model_seg(input logic [6:0] s, input logic [3:0] a, input int len);
        int d, v;
        ev_t e;
        if (len < LONG) return;
        d = lit_digit(a);
        if (d < 0) return;
        v = lookup(s);
        if (v < 0) begin
            m_dv[d] = 1'b0;
            m_bad   = 1'b1;
        end else begin
            if (!m_dv[d] || m_hex[d] != 4'(v)) begin
                if (rmode == 1 && exp_q.size() > 0) m_ovr = 1'b1;
                else begin e.dig = d; e.val = v; exp_q.push_back(e); end
            end
            m_hex[d] = 4'(v);
            m_dv[d]  = 1'b1;
        end
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] a, input int len);
        model_seg(s, a, len);
        bus.seg_n = s;
        bus.an_n  = a;
        last_s = s;
        last_a = a;
        repeat (len) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.seg_n = 7'h7F; bus.an_n = 4'hF; bus.clr_err = 1'b0;
        last_s = 7'h7F; last_a = 4'hF;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_hex"}, bus.hex_out, m_hex_word());
        chk({tag, "_dv"}, bus.digit_valid, m_dv_word());
    endtask

    // consumer: choose ready for the coming edge, then score the event accepted on it
    always @(negedge clk) begin
        case (rmode)
            0: bus.upd_ready = 1'b1;
            1: bus.upd_ready = 1'b0;
            default: begin
                bus.upd_ready = (lowrun >= 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
                lowrun = bus.upd_ready ? 0 : lowrun + 1;
            end
        endcase
        if (rst_n && bus.upd_valid && bus.upd_ready) begin
            n_ev++;
            if (exp_q.size() == 0) chk("evt_spurious", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                chk("evt_digit", bus.upd_digit, mon_e.dig);
                chk("evt_value", bus.upd_value, mon_e.val);
            end
        end
    end

    initial begin
        logic [6:0] s;
        logic [3:0] a;
        int len, r;
        bus.upd_ready = 1'b1;
`ifdef SSD_CAPTURE_DP_EN
        bus.dp_n = 1'b1;
`endif
        @(negedge clk);
        do_reset();

        // blank bus after reset
        hold(7'h7F, 4'hF, 50);
        chk("rst_hex", bus.hex_out, 0);
        chk("rst_dv", bus.digit_valid, 0);
        chk("rst_upd_valid", bus.upd_valid, 0);
        chk("rst_upd_digit", bus.upd_digit, 0);
        chk("rst_upd_value", bus.upd_value, 0);
        chk("rst_bad", bus.bad_pattern, 0);
        chk("rst_ovr", bus.overrun, 0);

        // single digit, event latency from pin change
        model_seg(7'h24, 4'hE, 20);
        bus.seg_n = 7'h24; bus.an_n = 4'hE; last_s = 7'h24; last_a = 4'hE;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.upd_valid && lat < 0) lat = k;
        end
        chk("t2_latency_ok", (lat >= 1 && lat <= 12), 1);
        chk("t2_hex", bus.hex_out[3:0], 4'h2);
        chk("t2_dv", bus.digit_valid, 4'b0001);

        // four-digit scan, three rounds
        ev0 = n_ev;
        for (int rd = 0; rd < 3; rd++) begin
            hold(7'h79, 4'hE, 30);
            hold(7'h08, 4'hD, 30);
            hold(7'h03, 4'hB, 30);
            hold(7'h0E, 4'h7, 30);
        end
        chk("t3_hex", bus.hex_out, 16'hFBA1);
        chk("t3_dv", bus.digit_valid, 4'hF);
        chk("t3_events", n_ev - ev0, 4);
        chk("t3_q_empty", exp_q.size(), 0);

        // consumer stalled across two captures
        do_reset();
        rmode = 1;
        hold(7'h79, 4'hE, 30);
        hold(7'h08, 4'hD, 30);
        chk("t4_valid", bus.upd_valid, 1);
        chk("t4_digit", bus.upd_digit, 0);
        chk("t4_value", bus.upd_value, 1);
        chk("t4_ovr", bus.overrun, m_ovr);
        chk_state("t4");
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        chk("t4_ovr_clr", bus.overrun, 0);
        rmode = 0;
        repeat (3) @(negedge clk);
        chk("t4_drained", bus.upd_valid, 0);
        chk("t4_q_empty", exp_q.size(), 0);

        // valid then invalid pattern on digit 1
        do_reset();
        hold(7'h79, 4'hD, 30);
        hold(7'h7F, 4'hD, 30);
        chk("t5_bad", bus.bad_pattern, m_bad);
        chk_state("t5");
        chk("t5_no_evt", bus.upd_valid, 0);
        chk("t5_q_empty", exp_q.size(), 0);

        // two digits lit, toggling segments, reset mid-settle
        hold(7'h24, 4'hC, 30);
        chk_state("t6_two_low");
        for (int k = 0; k < 8; k++) hold((k % 2) ? 7'h30 : 7'h24, 4'hE, 4);
        chk_state("t6_toggle");
        hold(7'h30, 4'hB, 5);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_hex", bus.hex_out, 0);
        chk("t6_rst_dv", bus.digit_valid, 0);
        chk("t6_rst_bad", bus.bad_pattern, 0);
        chk("t6_rst_valid", bus.upd_valid, 0);
        @(negedge clk);
        do_reset();

        // random segments with a jittery consumer
        rmode = 2;
        for (int k = 0; k < 80; k++) begin
            do begin
                r = $urandom_range(0, 9);
                s = (r < 7) ? seg_tab[$urandom_range(0, 15)] : (r < 9) ? 7'($urandom) : 7'h7F;
                r = $urandom_range(0, 9);
                a = (r < 7) ? ~(4'b0001 << $urandom_range(0, 3)) : (r < 8) ? 4'hF : 4'($urandom);
            end while ({s, a} == {last_s, last_a});
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(LONG, 28);
            hold(s, a, len);
            if (len >= LONG) chk_state($sformatf("rnd%0d", k));
        end
        rmode = 0;
        if ({last_s, last_a} == {7'h7F, 4'hF}) hold(7'h40, 4'hC, 5);
        hold(7'h7F, 4'hF, 20);
        chk("rnd_bad", bus.bad_pattern, m_bad);
        chk("rnd_ovr", bus.overrun, 0);
        chk("rnd_q_empty", exp_q.size(), 0);
        chk_state("rnd_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
